stage4_insn_queue: RTL and testbench

Decoupling FIFO between decode and execute in the four-stage pipeline; it implements the queue end of the stage-4 hazard protocol (consumes `flush_queue`/`stall_queue`, produces `is_queue_full`). Decode pushes decoded instruction bundles with their PC. Execute pops from the head. The hazard unit flushes the queue on redirect and stalls it while execute is held. It also tracks queued `vsetvl` instructions so the hazard unit can serialize vector configuration.

---
 rtl/rv32i_types_pkg.sv | 6 +
 rtl/stage4_queue_pkg.sv | 14 +
 rtl/stage4_insn_queue_if.sv | 37 +++
 rtl/stage4_insn_queue.sv | 104 ++++++++++
 tb/tb_stage4_insn_queue.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Base RV32I scalar types shared across the pipeline.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/stage4_queue_pkg.sv
// Shared constants and the default-width entry layout for the decode/execute queue.
package stage4_queue_pkg;

  localparam int QUEUE_DEPTH_DEFAULT  = 4;
  localparam int QUEUE_DATA_W_DEFAULT = 64;

  // Entry layout at the default bundle width; the queue re-declares it at its own DATA_W.
  typedef struct packed {
    logic [QUEUE_DATA_W_DEFAULT-1:0] bundle;
    rv32i_types_pkg::word_t          pc;
    logic                            vsetvl;
  } insn_entry_t;

endpackage

// File: rtl/stage4_insn_queue_if.sv
// Decode push, execute pop and hazard-unit control/status signals of the instruction queue.
interface stage4_insn_queue_if
  import stage4_queue_pkg::*;
#(
  parameter int DEPTH  = QUEUE_DEPTH_DEFAULT,
  parameter int DATA_W = QUEUE_DATA_W_DEFAULT
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   queue_wen;
  logic [DATA_W-1:0]      wdata;
  rv32i_types_pkg::word_t wpc;
  logic                   wvsetvl;
  logic                   deq;
  logic                   stall_queue;
  logic                   flush_queue;
  logic                   is_queue_full;
  logic                   is_queue_empty;
  logic                   rvalid;
  logic [DATA_W-1:0]      rdata;
  rv32i_types_pkg::word_t rpc;
  logic                   rvsetvl;
  logic [CNT_W-1:0]       count;
  logic                   vsetvl_pending;

  modport master (
    output queue_wen, wdata, wpc, wvsetvl, deq, stall_queue, flush_queue,
    input  is_queue_full, is_queue_empty, rvalid, rdata, rpc, rvsetvl, count, vsetvl_pending
  );

  modport slave (
    input  queue_wen, wdata, wpc, wvsetvl, deq, stall_queue, flush_queue,
    output is_queue_full, is_queue_empty, rvalid, rdata, rpc, rvsetvl, count, vsetvl_pending
  );

endinterface

// File: rtl/stage4_insn_queue.sv
// Decode-to-execute instruction FIFO: circular storage, flush/stall hazard handling,
// and a running count of queued vsetvl instructions.
module stage4_insn_queue
  import stage4_queue_pkg::*;
#(
  parameter int DEPTH  = QUEUE_DEPTH_DEFAULT,
  parameter int DATA_W = QUEUE_DATA_W_DEFAULT
) (
  input logic                CLK,
  input logic                nRST,
  stage4_insn_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0]      bundle;
    rv32i_types_pkg::word_t pc;
    logic                   vsetvl;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] vcnt_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] vcnt_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             vinc_s;
  logic             vdec_s;
  entry_t           head_s;
  entry_t           wentry_s;

  // Handshake qualification and next occupancy; full is judged before any same-cycle pop.
  always_comb begin
    full_s      = (count_r == CNT_W'(DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    push_s      = q.queue_wen && !full_s && !q.flush_queue;
    pop_s       = q.deq && !empty_s && !q.stall_queue && !q.flush_queue;
    head_s      = mem_r[rptr_r];
    wentry_s    = '{bundle: q.wdata, pc: q.wpc, vsetvl: q.wvsetvl};
    vinc_s      = push_s && q.wvsetvl;
    vdec_s      = pop_s && head_s.vsetvl;
    count_nxt_s = count_r;
    vcnt_nxt_s  = vcnt_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    case ({vinc_s, vdec_s})
      2'b10:   vcnt_nxt_s = vcnt_r + CNT_W'(1);
      2'b01:   vcnt_nxt_s = vcnt_r - CNT_W'(1);
      default: vcnt_nxt_s = vcnt_r;
    endcase
  end

  // Entry storage; contents are don't-care until the count covers them.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wptr_r] <= wentry_s;
    end
  end

  // Pointers and counters; flush empties the queue with priority over push/pop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      vcnt_r  <= {CNT_W{1'b0}};
    end else if (q.flush_queue) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      vcnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      vcnt_r  <= vcnt_nxt_s;
    end
  end

  // Head fields read straight from storage and zeroed while the queue is empty.
  assign q.is_queue_full  = full_s;
  assign q.is_queue_empty = empty_s;
  assign q.rvalid         = !empty_s;
  assign q.rdata          = empty_s ? {DATA_W{1'b0}} : head_s.bundle;
  assign q.rpc            = empty_s ? 32'h0000_0000 : head_s.pc;
  assign q.rvsetvl        = empty_s ? 1'b0 : head_s.vsetvl;
  assign q.count          = count_r;
  assign q.vsetvl_pending = (vcnt_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_stage4_insn_queue.sv
// Scenario bench for stage4_insn_queue: a queue scoreboard models accepted pushes/pops
// and each scenario task compares the DUT head and flags against it.
module tb_stage4_insn_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;

  typedef struct {
    logic [63:0] data;
    logic [31:0] pc;
    logic        vs;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  stage4_insn_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) q ();

  stage4_insn_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .q    (q.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bundle_of(input logic [31:0] pc);
    return {~pc, pc ^ 32'h5A5A_0000};
  endfunction

  function automatic bit model_pending();
    foreach (sb[i]) if (sb[i].vs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    q.queue_wen   = 1'b0;
    q.wdata       = 64'h0;
    q.wpc         = 32'h0;
    q.wvsetvl     = 1'b0;
    q.deq         = 1'b0;
    q.stall_queue = 1'b0;
    q.flush_queue = 1'b0;
  endtask

  // Drive one clock of stimulus and update the scoreboard with what the queue must accept.
  task automatic cycle(input bit wen, input logic [31:0] pc, input bit vs,
                       input bit deq, input bit stall, input bit flush);
    bit push_ok, pop_ok;
    q.queue_wen   = wen;
    q.wpc         = pc;
    q.wdata       = bundle_of(pc);
    q.wvsetvl     = vs;
    q.deq         = deq;
    q.stall_queue = stall;
    q.flush_queue = flush;
    push_ok = wen && (sb.size() < DEPTH) && !flush;
    pop_ok  = deq && (sb.size() > 0) && !stall && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back('{bundle_of(pc), pc, vs});
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    #12;
    n_vec++;
    if (q.rvalid !== 1'b0 || q.is_queue_empty !== 1'b1 || q.is_queue_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: rvalid=%b empty=%b full=%b, required 0 1 0",
               q.rvalid, q.is_queue_empty, q.is_queue_full);
    end
    n_vec++;
    if (q.count !== 3'd0 || q.rpc !== 32'h0 || q.rdata !== 64'h0 || q.rvsetvl !== 1'b0 ||
        q.vsetvl_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_head: count=%0d rpc=%h rdata=%h rvsetvl=%b pend=%b, required all 0",
               q.count, q.rpc, q.rdata, q.rvsetvl, q.vsetvl_pending);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (q.rvalid !== 1'b0 || q.count !== 3'd0 || q.rpc !== 32'h0) begin
      n_err++;
      $display("FAIL idle_after_reset: rvalid=%b count=%0d rpc=%h, required 0 0 0",
               q.rvalid, q.count, q.rpc);
    end
  endtask

  task automatic test_push_latency();
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.rvalid !== 1'b1 || q.rpc !== 32'h100 || q.count !== 3'd1 || q.rdata !== bundle_of(32'h100)) begin
      n_err++;
      $display("FAIL push_latency: rvalid=%b rpc=%h count=%0d rdata=%h, required 1 100 1 %h",
               q.rvalid, q.rpc, q.count, q.rdata, bundle_of(32'h100));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.is_queue_empty !== 1'b1 || q.rdata !== 64'h0) begin
      n_err++;
      $display("FAIL pop_single: empty=%b rdata=%h, required 1 0", q.is_queue_empty, q.rdata);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.is_queue_full !== 1'b1 || q.count !== 3'd4) begin
      n_err++;
      $display("FAIL fill_full: full=%b count=%0d, required 1 4", q.is_queue_full, q.count);
    end
    cycle(1'b1, 32'h210, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.count !== 3'd4 || q.rpc !== 32'h200) begin
      n_err++;
      $display("FAIL push_when_full: count=%0d rpc=%h, required 4 200", q.count, q.rpc);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sb.size() == 0 || q.rpc !== 32'h200 + 32'(4 * i) || q.rdata !== sb[0].data) begin
        n_err++;
        $display("FAIL fill_order[%0d]: rpc=%h rdata=%h, required %h %h", i, q.rpc, q.rdata,
                 32'h200 + 32'(4 * i), bundle_of(32'h200 + 32'(4 * i)));
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_vec++;
    if (q.is_queue_empty !== 1'b1 || q.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drained: empty=%b rvalid=%b, required 1 0", q.is_queue_empty, q.rvalid);
    end
    // Full with a legal pop still turns the push away.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h220 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h230, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.count !== 3'd3 || q.is_queue_full !== 1'b0 || q.rpc !== 32'h224) begin
      n_err++;
      $display("FAIL full_push_pop: count=%0d full=%b rpc=%h, required 3 0 224",
               q.count, q.is_queue_full, q.rpc);
    end
    while (sb.size() > 0) begin
      n_vec++;
      if (q.rpc !== sb[0].pc) begin
        n_err++;
        $display("FAIL full_push_pop_drain: rpc=%h, required %h", q.rpc, sb[0].pc);
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      n_vec++;
      if (q.rpc !== 32'h300 + 32'(4 * (k - 1)) || q.count !== 3'd1) begin
        n_err++;
        $display("FAIL wrap[%0d]: rpc=%h count=%0d, required %h 1", k, q.rpc, q.count,
                 32'h300 + 32'(4 * (k - 1)));
      end
      cycle(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_vec++;
    if (q.rpc !== 32'h324 || q.count !== 3'd1) begin
      n_err++;
      $display("FAIL wrap_last: rpc=%h count=%0d, required 324 1", q.rpc, q.count);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(i == 2, 32'h408, 1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (q.rpc !== 32'h400 || q.count !== ((i == 2) ? 3'd3 : 3'd2)) begin
        n_err++;
        $display("FAIL stall[%0d]: rpc=%h count=%0d, required 400 %0d", i, q.rpc, q.count,
                 (i == 2) ? 3 : 2);
      end
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.rpc !== 32'h404 || q.count !== 3'd2) begin
      n_err++;
      $display("FAIL stall_release: rpc=%h count=%0d, required 404 2", q.rpc, q.count);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h508, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.vsetvl_pending !== 1'b1 || q.count !== 3'd3) begin
      n_err++;
      $display("FAIL pre_flush: pend=%b count=%0d, required 1 3", q.vsetvl_pending, q.count);
    end
    cycle(1'b1, 32'h50C, 1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (q.count !== 3'd0 || q.rvalid !== 1'b0 || q.vsetvl_pending !== 1'b0 || q.rpc !== 32'h0 ||
        q.is_queue_empty !== 1'b1) begin
      n_err++;
      $display("FAIL flush: count=%0d rvalid=%b pend=%b rpc=%h empty=%b, required 0 0 0 0 1",
               q.count, q.rvalid, q.vsetvl_pending, q.rpc, q.is_queue_empty);
    end
    cycle(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.rpc !== sb[0].pc || q.count !== 3'd1 || q.vsetvl_pending !== 1'b0) begin
      n_err++;
      $display("FAIL post_flush_push: rpc=%h count=%0d pend=%b, required 600 1 0",
               q.rpc, q.count, q.vsetvl_pending);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_vsetvl();
    cycle(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h708, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.vsetvl_pending !== 1'b1) begin
      n_err++;
      $display("FAIL vset_pending: pend=%b, required 1", q.vsetvl_pending);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.rvsetvl !== 1'b1 || q.rpc !== 32'h704) begin
      n_err++;
      $display("FAIL vset_head: rvsetvl=%b rpc=%h, required 1 704", q.rvsetvl, q.rpc);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.vsetvl_pending !== model_pending() || q.vsetvl_pending !== 1'b0 || q.rpc !== 32'h708) begin
      n_err++;
      $display("FAIL vset_cleared: pend=%b rpc=%h, required 0 708", q.vsetvl_pending, q.rpc);
    end
    cycle(1'b1, 32'h70C, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h710, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.vsetvl_pending !== 1'b1 || q.count !== 3'd1 || q.rpc !== 32'h710 || q.rvsetvl !== 1'b1) begin
      n_err++;
      $display("FAIL vset_push_pop: pend=%b count=%0d rpc=%h rvsetvl=%b, required 1 1 710 1",
               q.vsetvl_pending, q.count, q.rpc, q.rvsetvl);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (q.vsetvl_pending !== 1'b0 || q.is_queue_empty !== 1'b1) begin
      n_err++;
      $display("FAIL vset_drained: pend=%b empty=%b, required 0 1", q.vsetvl_pending, q.is_queue_empty);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h804, 1'b1, 1'b0, 1'b0, 1'b0);
    nrst = 1'b0;
    #2;
    sb.delete();
    n_vec++;
    if (q.count !== 3'd0 || q.rvalid !== 1'b0 || q.vsetvl_pending !== 1'b0 || q.rpc !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d rvalid=%b pend=%b rpc=%h, required 0 0 0 0",
               q.count, q.rvalid, q.vsetvl_pending, q.rpc);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.rpc !== 32'h900 || q.count !== 3'd1 || q.vsetvl_pending !== 1'b0) begin
      n_err++;
      $display("FAIL after_mid_reset: rpc=%h count=%0d pend=%b, required 900 1 0",
               q.rpc, q.count, q.vsetvl_pending);
    end
  endtask

  initial begin
    test_reset();
    test_push_latency();
    test_fill();
    test_wrap();
    test_stall();
    test_flush();
    test_vsetvl();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
